// File: rtl/filter_job_if.sv
// Button, PC and status bundle between the board/GPU side and filter_job_ctrl.
// master drives buttons and pc_in; slave (the controller) drives everything else.
interface filter_job_if #(parameter int PC_W = 32);
  logic            identity_n;
  logic            kernel1_n;
  logic            kernel2_n;
  logic            kernel3_n;
  logic [PC_W-1:0] pc_in;
  logic [1:0]      kernel;
  logic [PC_W-1:0] pc_out;
  logic            gpu_rst;
  logic            busy;
  logic            done;
  logic [7:0]      run_count;
  logic [7:0]      abort_count;

  modport master (
    output identity_n, kernel1_n, kernel2_n, kernel3_n, pc_in,
    input  kernel, pc_out, gpu_rst, busy, done, run_count, abort_count
  );
  modport slave (
    input  identity_n, kernel1_n, kernel2_n, kernel3_n, pc_in,
    output kernel, pc_out, gpu_rst, busy, done, run_count, abort_count
  );
endinterface

// File: rtl/filter_job_ctrl.sv
// Filter GPU job sequencer: debounced kernel buttons, GPU restart, run monitoring
// until the end PC, and completion/abort status.
module filter_btn_debounce #(
  parameter int CYCLES = 16
) (
  input  logic CLK,
  input  logic reset,
  input  logic raw_n,
  output logic press
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        // CYCLES-th consecutive differing sample: accept the new level
        level <= sync2;
        cnt   <= '0;
        press <= level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module filter_job_ctrl #(
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter int              RESTART_CYCLES  = 8,
  parameter int              PC_W            = 32,
  parameter logic [PC_W-1:0] END_PC          = 200
) (
  input logic         CLK,
  input logic         reset,
  filter_job_if.slave bus
);
  localparam int RW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;

  typedef enum logic [1:0] {S_RESTART, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [RW-1:0]   rcnt;
  logic [PC_W-1:0] pc_s;
  logic            end_prev;
  logic [3:0]      btn_n, press;
  logic            any_press;
  logic [1:0]      sel;

  assign btn_n = {bus.kernel3_n, bus.kernel2_n, bus.kernel1_n, bus.identity_n};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    filter_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .CLK  (CLK),
      .reset(reset),
      .raw_n(btn_n[i]),
      .press(press[i])
    );
  end

  // Lowest index wins: identity > kernel1 > kernel2 > kernel3
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (press[i]) sel = 2'(i);
  end
  assign any_press = |press;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state           <= S_RESTART;
      rcnt            <= '0;
      pc_s            <= '0;
      end_prev        <= 1'b0;
      bus.kernel      <= 2'd0;
      bus.pc_out      <= '0;
      bus.gpu_rst     <= 1'b1;
      bus.busy        <= 1'b1;
      bus.done        <= 1'b0;
      bus.run_count   <= 8'd0;
      bus.abort_count <= 8'd0;
    end else begin
      pc_s     <= bus.pc_in;
      end_prev <= 1'b0;
      case (state)
        S_RESTART: begin
          if (any_press) begin
            bus.kernel <= sel;
            rcnt       <= '0;
          end else if (rcnt == RW'(RESTART_CYCLES - 1)) begin
            state       <= S_RUN;
            rcnt        <= '0;
            bus.gpu_rst <= 1'b0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        S_RUN: begin
          bus.pc_out <= bus.pc_in;
          // pc_in crosses from clkProc: require END_PC on two consecutive samples
          end_prev   <= (pc_s == END_PC);
          if (any_press) begin
            state           <= S_RESTART;
            rcnt            <= '0;
            bus.kernel      <= sel;
            bus.abort_count <= bus.abort_count + 8'd1;
            bus.gpu_rst     <= 1'b1;
            bus.pc_out      <= '0;
          end else if (pc_s == END_PC && end_prev) begin
            state         <= S_DONE;
            bus.run_count <= bus.run_count + 8'd1;
            bus.gpu_rst   <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.pc_out    <= END_PC;
          end
        end
        S_DONE: begin
          if (any_press) begin
            state       <= S_RESTART;
            rcnt        <= '0;
            bus.kernel  <= sel;
            bus.busy    <= 1'b1;
            bus.done    <= 1'b0;
            bus.pc_out  <= '0;
          end
        end
        default: state <= S_RESTART;
      endcase
    end
  end
endmodule

// File: doc/filter_job_ctrl.md
Name: filter_job_ctrl

Overview:
- Sequences filter runs on the filter GPU: debounces the four active-low board buttons, selects the kernel, restarts the GPU PC, monitors the run until the program end, and reports status.
- Sits between the board buttons, the instruction memory address/kernel inputs and the GPU reset.
- Replaces ad-hoc button/PC muxing with one FSM.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable CLK samples required before a button level is accepted.
- RESTART_CYCLES, 8, CLK cycles gpu_rst is held per restart. Must be at least 2x the clkProc divide ratio.
- END_PC, 32'd200, PC value that marks end of the filter program.
- PC_W, 32, PC width.

Ports:
- CLK  in  1  system clock.
- reset  in  1  synchronous, active-high.
- identity_n  in  1  identity button, active-low, asynchronous to CLK.
- kernel1_n  in  1  kernel 1 button, active-low.
- kernel2_n  in  1  kernel 2 button, active-low.
- kernel3_n  in  1  kernel 3 button, active-low.
- pc_in  in  PC_W  current PC from the filter GPU (clkProc domain).
- kernel  out  2  selected kernel, to imem and vectorMemory.
- pc_out  out  PC_W  instruction address to imem.
- gpu_rst  out  1  active-high reset to the filter GPU.
- busy  out  1  restart or run in progress.
- done  out  1  last run reached END_PC.
- run_count  out  8  completed runs, wraps at 255->0.
- abort_count  out  8  runs aborted by a press, wraps.

Behaviour:
- Reset values:
  - kernel=0, pc_out=0, gpu_rst=1, busy=1, done=0, run_count=0, abort_count=0.
  - All debounced levels=1 (released).
  - state=RESTART with restart counter=0.
- Button path (per button):
  - 2-flop synchronizer.
  - Counter increments while the synced level differs from the debounced level, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips.
  - A press event is a 1->0 flip, one cycle wide.
  - Raw low to press event: DEBOUNCE_CYCLES+2 edges. Press event to kernel update: 1 edge.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Priority for simultaneous press events: identity(0) > kernel1(1) > kernel2(2) > kernel3(3). Only one kernel is selected per cycle.
- Holding a button generates exactly one event. Release generates none.
- States:
  - RESTART:
    - gpu_rst=1, pc_out=0, busy=1, done=0.
    - Counter counts 0..RESTART_CYCLES-1, then goes to RUN.
    - A press in RESTART loads the new kernel and clears the counter. abort_count does not change.
  - RUN:
    - gpu_rst=0, busy=1, pc_out=pc_in (registered, 1-cycle latency).
    - End is detected when the registered pc_in equals END_PC on 2 consecutive CLK samples; this guards the clock-domain crossing. On end, go to DONE and increment run_count.
    - A press in RUN loads the kernel, increments abort_count and goes to RESTART.
    - If a press and the end condition occur in the same cycle, the press wins: abort, no run_count increment.
  - DONE:
    - gpu_rst=1 (GPU frozen), pc_out=END_PC, busy=0, done=1.
    - Any press, including the same kernel, loads the kernel and goes to RESTART, which reruns the filter.
- kernel changes only on a press event and is never X.
- pc_in values above END_PC are treated as not-end. The run continues until a press.
- Asserting reset in any state (mid-run included) returns all outputs to reset values on the next edge. Debounce counters clear.

Test Plan:
- Reset release with no buttons -> gpu_rst=1 for 8 cycles, then RUN with kernel=0. Drive pc_in 0..200 -> done=1, busy=0, run_count=1, pc_out=200.
- Hold kernel2_n low for 40 cycles while in DONE -> exactly one event; kernel=2 at edge 19 after first low sample. RESTART lasts 8 cycles. run_count unchanged until pc_in reaches 200 twice, then run_count=2.
- 10-cycle low pulse on kernel1_n -> no kernel change, state unchanged.
- Press kernel3 in RUN at pc_in=57 -> kernel=3, abort_count=1, gpu_rst=1, pc_out=0. After completion, run_count increments and abort_count stays 1.
- identity_n and kernel1_n fall on the same cycle -> kernel=0. Press at the same cycle as the second END_PC sample -> abort taken, run_count unchanged.
- Assert reset mid-RUN at pc_in=120 -> next edge: kernel=0, pc_out=0, gpu_rst=1, counts=0. 255 completed runs plus one more -> run_count wraps to 0.
